// File: rtl/shift_seq_pkg.sv
// Shared definitions for the serial shift sequencer: FSM state encodings
// and the counter-width helper.
package shift_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_GAP   = ST_GAP
    } state_t;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_seq_datapath.sv
// Parallel-load shift register with a registered serial output bit.
// The word is reordered at load so the next bit is always at the top.
module shift_seq_datapath
    import shift_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] word,
    output logic             serial_out
);

    function automatic logic [WIDTH-1:0] order_word(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST != 0) begin
            r = w;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r[WIDTH-1-i] = w[i];
            end
        end
        return r;
    endfunction

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] word_ord;

    assign word_ord = order_word(word);

    always_ff @(posedge clock) begin
        if (load) begin
            sreg <= word_ord;
        end else if (step) begin
            sreg <= sreg << 1;
        end
    end

    // Output bit is the lookahead of the register, so it is valid in the
    // same cycle the controller reports the matching bit index.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            serial_out <= 1'b0;
        end else if (load) begin
            serial_out <= word_ord[WIDTH-1];
        end else if (step) begin
            serial_out <= sreg[WIDTH-2];
        end else begin
            serial_out <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Word-to-serial sequencer: valid/ready intake, one-word holding register,
// IDLE/SHIFT/GAP FSM, bit and gap counters, framing strobes.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int GAP       = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     load_valid,
    output logic                     load_ready,
    output logic                     serial_out,
    output logic                     shift_en,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     done,
    output logic                     busy
);

    localparam int CW = cnt_w(WIDTH);
    localparam int GW = cnt_w(GAP);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt_q;
    logic [GW-1:0]    gap_q;
    logic             hold_full;
    logic [WIDTH-1:0] hold_word;

    logic             accept;
    logic             last_bit;
    logic             gap_end;
    logic             load_sr;
    logic             from_hold;
    logic             hold_wr;
    logic             step;
    logic [WIDTH-1:0] load_word;

    assign load_ready = !hold_full;
    assign accept     = load_valid && load_ready;
    assign last_bit   = (state == S_SHIFT) && (cnt_q == BIT_LAST);
    assign gap_end    = (state == S_GAP) && (gap_q == GAP_LAST);

    always_comb begin
        state_nxt = state;
        load_sr   = 1'b0;
        from_hold = 1'b0;
        case (state)
            S_IDLE: begin
                // A word parked in hold at the very end of a gap is picked
                // up here, since load_ready stays low while it waits.
                if (hold_full) begin
                    state_nxt = S_SHIFT;
                    load_sr   = 1'b1;
                    from_hold = 1'b1;
                end else if (accept) begin
                    state_nxt = S_SHIFT;
                    load_sr   = 1'b1;
                end
            end
            S_SHIFT: begin
                if (last_bit) begin
                    if (GAP > 0) begin
                        state_nxt = S_GAP;
                    end else if (hold_full) begin
                        load_sr   = 1'b1;
                        from_hold = 1'b1;
                    end else if (accept) begin
                        load_sr   = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    if (hold_full) begin
                        state_nxt = S_SHIFT;
                        load_sr   = 1'b1;
                        from_hold = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Accepted words bypass hold only when they go straight into the shifter.
    assign hold_wr   = accept && !(load_sr && !from_hold);
    assign load_word = from_hold ? hold_word : data_in;
    assign step      = (state == S_SHIFT) && !last_bit;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= S_IDLE;
            cnt_q     <= '0;
            gap_q     <= '0;
            hold_full <= 1'b0;
        end else begin
            state <= state_nxt;

            if (step) begin
                cnt_q <= cnt_q + CW'(1);
            end else begin
                cnt_q <= '0;
            end

            if ((state == S_GAP) && !gap_end) begin
                gap_q <= gap_q + GW'(1);
            end else begin
                gap_q <= '0;
            end

            if (from_hold) begin
                hold_full <= 1'b0;
            end else if (hold_wr) begin
                hold_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (hold_wr) begin
            hold_word <= data_in;
        end
    end

    shift_seq_datapath #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_datapath (
        .clock      (clock),
        .clear      (clear),
        .load       (load_sr),
        .step       (step),
        .word       (load_word),
        .serial_out (serial_out)
    );

    assign shift_en = (state == S_SHIFT);
    assign bit_cnt  = cnt_q;
    assign done     = last_bit;
    assign busy     = (state != S_IDLE) || hold_full;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: three instances cover GAP=2/MSB-first,
// GAP=0/MSB-first and GAP=0/LSB-first.
module tb_shift_seq_ctrl;

    logic clock = 1'b0;
    logic clear = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] a_data, b_data, c_data;
    logic       a_valid, b_valid, c_valid;
    logic       a_ready, b_ready, c_ready;
    logic       a_ser, b_ser, c_ser;
    logic       a_sen, b_sen, c_sen;
    logic [2:0] a_cnt, b_cnt, c_cnt;
    logic       a_done, b_done, c_done;
    logic       a_busy, b_busy, c_busy;

    shift_seq_ctrl #(.WIDTH(8), .GAP(2), .MSB_FIRST(1)) dut_a (
        .clock(clock), .clear(clear), .data_in(a_data), .load_valid(a_valid),
        .load_ready(a_ready), .serial_out(a_ser), .shift_en(a_sen),
        .bit_cnt(a_cnt), .done(a_done), .busy(a_busy));

    shift_seq_ctrl #(.WIDTH(8), .GAP(0), .MSB_FIRST(1)) dut_b (
        .clock(clock), .clear(clear), .data_in(b_data), .load_valid(b_valid),
        .load_ready(b_ready), .serial_out(b_ser), .shift_en(b_sen),
        .bit_cnt(b_cnt), .done(b_done), .busy(b_busy));

    shift_seq_ctrl #(.WIDTH(8), .GAP(0), .MSB_FIRST(0)) dut_c (
        .clock(clock), .clear(clear), .data_in(c_data), .load_valid(c_valid),
        .load_ready(c_ready), .serial_out(c_ser), .shift_en(c_sen),
        .bit_cnt(c_cnt), .done(c_done), .busy(c_busy));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0]  s1_bits;
        logic [15:0] s2_bits;
        logic [7:0]  words [3];
        logic [23:0] stream;
        logic [7:0]  w5;
        int          idx, acc33, nbits, nsen;
        logic        acc;

        s1_bits = 8'b1011_0100;
        s2_bits = 16'b1010_0101_0011_1100;
        words   = '{8'h11, 8'h22, 8'h33};

        a_data = '0; b_data = '0; c_data = '0;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;

        // reset state
        #2;
        check("rst_ser",   a_ser,   1'b0);
        check("rst_sen",   a_sen,   1'b0);
        check("rst_done",  a_done,  1'b0);
        check("rst_busy",  a_busy,  1'b0);
        check("rst_cnt",   a_cnt,   3'd0);
        check("rst_ready", a_ready, 1'b1);
        tick;
        check("rst_busy_b",  b_busy,  1'b0);
        check("rst_ready_c", c_ready, 1'b1);
        #2 clear = 1'b1;
        tick;

        // idle stall
        for (int i = 0; i < 20; i++) begin
            check("idle_sen",   a_sen,   1'b0);
            check("idle_busy",  a_busy,  1'b0);
            check("idle_done",  a_done,  1'b0);
            check("idle_ready", a_ready, 1'b1);
            tick;
        end

        // single word 8'hB4, GAP=2, MSB first
        a_data = 8'hB4; a_valid = 1'b1;
        tick;
        a_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check("s1_sen",  a_sen,  1'b1);
            check("s1_ser",  a_ser,  s1_bits[8-c]);
            check("s1_cnt",  a_cnt,  c - 1);
            check("s1_done", a_done, (c == 8));
            check("s1_busy", a_busy, 1'b1);
            tick;
        end
        for (int c = 9; c <= 10; c++) begin
            check("s1_gap_sen",  a_sen,  1'b0);
            check("s1_gap_ser",  a_ser,  1'b0);
            check("s1_gap_busy", a_busy, 1'b1);
            check("s1_gap_cnt",  a_cnt,  3'd0);
            tick;
        end
        check("s1_end_busy",  a_busy,  1'b0);
        check("s1_end_ready", a_ready, 1'b1);

        // holding register, GAP=2: 11, 22, 33 offered continuously
        idx = 0; acc33 = -1; stream = '0; nbits = 0;
        for (int cyc = 0; cyc <= 33; cyc++) begin
            if (a_sen) begin
                stream = {stream[22:0], a_ser};
                nbits++;
            end
            a_valid = (idx < 3);
            a_data  = (idx < 3) ? words[idx] : 8'h00;
            if (cyc inside {0, 1, 11}) check("s3_ready_hi", a_ready, 1'b1);
            if (cyc inside {2, 5, 10, 12, 20}) check("s3_ready_lo", a_ready, 1'b0);
            acc = a_valid && a_ready;
            if (acc && idx == 2) acc33 = cyc;
            tick;
            if (acc) idx++;
        end
        a_valid = 1'b0;
        check("s3_acc33_edge", acc33, 11);
        check("s3_nbits", nbits, 24);
        check("s3_stream", stream, 24'h112233);
        check("s3_busy_end", a_busy, 1'b0);

        // back-to-back, GAP=0: A5 then 3C
        b_data = 8'hA5; b_valid = 1'b1;
        tick;
        b_data = 8'h3C;
        for (int c = 1; c <= 16; c++) begin
            check("s2_sen",  b_sen,  1'b1);
            check("s2_ser",  b_ser,  s2_bits[16-c]);
            check("s2_cnt",  b_cnt,  (c - 1) % 8);
            check("s2_done", b_done, (c == 8) || (c == 16));
            tick;
            if (c == 1) b_valid = 1'b0;
        end
        check("s2_end_sen",  b_sen,  1'b0);
        check("s2_end_busy", b_busy, 1'b0);

        // LSB first, GAP=0: 8'h01
        c_data = 8'h01; c_valid = 1'b1;
        tick;
        c_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check("s4_sen",  c_sen,  1'b1);
            check("s4_ser",  c_ser,  (c == 1));
            check("s4_cnt",  c_cnt,  c - 1);
            check("s4_done", c_done, (c == 8));
            tick;
        end
        check("s4_end_sen",  c_sen,  1'b0);
        check("s4_end_busy", c_busy, 1'b0);

        // mid-word reset: FF shifting, 0F in hold
        a_data = 8'hFF; a_valid = 1'b1;
        tick;
        a_data = 8'h0F;
        tick;
        a_valid = 1'b0;
        tick;
        tick;
        check("s5_pre_cnt",   a_cnt,   3'd3);
        check("s5_pre_ser",   a_ser,   1'b1);
        check("s5_pre_ready", a_ready, 1'b0);
        #2 clear = 1'b0;
        #1;
        check("s5_rst_ser",   a_ser,   1'b0);
        check("s5_rst_sen",   a_sen,   1'b0);
        check("s5_rst_done",  a_done,  1'b0);
        check("s5_rst_busy",  a_busy,  1'b0);
        check("s5_rst_cnt",   a_cnt,   3'd0);
        check("s5_rst_ready", a_ready, 1'b1);
        tick;
        #2 clear = 1'b1;
        nsen = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (a_sen) nsen++;
        end
        check("s5_quiet_sen",  nsen,   0);
        check("s5_quiet_busy", a_busy, 1'b0);
        a_data = 8'h5A; a_valid = 1'b1;
        tick;
        a_valid = 1'b0;
        w5 = '0;
        for (int c = 1; c <= 8; c++) begin
            check("s5_new_sen", a_sen, 1'b1);
            w5 = {w5[6:0], a_ser};
            tick;
        end
        check("s5_new_word", w5, 8'h5A);
        tick;
        tick;
        check("s5_final_sen",  a_sen,  1'b0);
        check("s5_final_busy", a_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
